fifo_byte_packer: RTL and testbench

//   Read-side controller for the team's 8-bit synchronous FIFO. Pops bytes by pulsing rd

---
 rtl/fifo_byte_packer.sv | 114 +++++++++++
 tb/tb_fifo_byte_packer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_packer.sv
// Read-side byte packer for the 8-bit synchronous FIFO: pops bytes and packs PACK of them
// (first popped byte in lane 0) into one word on a valid/ready stream; flush emits partial words.
//
// state   | meaning
// S_FILL  | popping and assembling; full words move into the output slot
// S_FLUSH | pops halted; wait for the in-flight byte, then emit the partial word (or nothing)
module fifo_byte_packer #(
  parameter int PACK = 4,
  parameter int BW   = $clog2(PACK + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifo_empty,
  output logic                fifo_rd,
  input  logic [7:0]          fifo_data,
  input  logic                flush,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [8*PACK-1:0]   m_data,
  output logic [BW-1:0]       m_bytes,
  output logic                busy
);

  typedef enum logic {S_FILL, S_FLUSH} state_t;

  localparam logic [BW-1:0] FULL   = BW'(PACK);
  localparam logic [BW:0]   FULL_X = (BW + 1)'(PACK);

  state_t                 state, state_nxt;
  logic [PACK-1:0][7:0]   asm_q;
  logic [PACK-1:0][7:0]   part;
  logic [BW-1:0]          fill;
  logic [BW-1:0]          lane;
  logic                   inflight;
  logic                   flush_pend;
  logic                   slot_free;
  logic                   xfer;
  logic                   emit;
  logic                   room;

  always_comb begin
    flush_pend = (state == S_FLUSH);
    slot_free  = !m_valid || m_ready;
    xfer       = (fill == FULL) && slot_free;
    // a pop already in flight reserves its lane
    room       = ({1'b0, fill} + {{BW{1'b0}}, inflight}) < FULL_X;
    fifo_rd    = !fifo_empty && !flush_pend && (room || xfer);
    emit       = flush_pend && !inflight && (fill != '0) && (fill != FULL) && slot_free;
    lane       = xfer ? '0 : fill;
    busy       = (fill != '0) || inflight || m_valid || flush_pend;
  end

  // partial word: lanes at or above fill are forced to zero
  always_comb begin
    part = '0;
    for (int k = 0; k < PACK; k++) begin
      if (BW'(k) < fill) part[k] = asm_q[k];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (flush) state_nxt = S_FLUSH;
      S_FLUSH: if (!inflight && ((fill == '0) || emit)) state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FILL;
      asm_q    <= '0;
      fill     <= '0;
      inflight <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_bytes  <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd;

      if (xfer) begin
        m_data  <= asm_q;
        m_bytes <= FULL;
        m_valid <= 1'b1;
      end else if (emit) begin
        m_data  <= part;
        m_bytes <= fill;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      for (int k = 0; k < PACK; k++) begin
        if (inflight && (BW'(k) == lane)) asm_q[k] <= fifo_data;
      end

      if (inflight) begin
        fill <= xfer ? BW'(1) : fill + BW'(1);
      end else if (xfer || emit) begin
        fill <= '0;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) fifo_rd |-> !fifo_empty);
  a_fill_range:   assert property (@(posedge clk) disable iff (rst) fill <= FULL);
  a_hold_stable:  assert property (@(posedge clk) disable iff (rst)
                    (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_bytes)));
`endif

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Self-checking bench for fifo_byte_packer: models the FIFO with a byte queue and
// scoreboards expected words, grouping pushed bytes into words at push/flush time.
module tb_fifo_byte_packer;
  localparam int PACK = 4;
  localparam int BW   = 3;
  localparam int W    = 8 * PACK;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [BW-1:0] bytes;
  } word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [7:0]    fifo_data;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [BW-1:0] m_bytes;
  logic          busy;

  always #5 clk = ~clk;

  fifo_byte_packer #(.PACK(PACK), .BW(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_data  (fifo_data),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_bytes    (m_bytes),
    .busy       (busy)
  );

  int            n_chk = 0;
  int            n_err = 0;
  logic [7:0]    fq[$];
  logic [7:0]    grp[$];
  word_t         exp_q[$];
  int            cyc_n = 0;
  int            last_hs = -1;
  int            pops = 0;
  logic          gap_on = 1'b0;
  logic          stall_prev = 1'b0;
  logic [W-1:0]  data_prev;
  logic [BW-1:0] bytes_prev;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic close_group();
    word_t w;
    if (grp.size() > 0) begin
      w.data  = '0;
      w.bytes = BW'(grp.size());
      for (int i = 0; i < grp.size(); i++) w.data[8*i +: 8] = grp[i];
      exp_q.push_back(w);
      grp.delete();
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    grp.push_back(b);
    if (grp.size() == PACK) close_group();
  endtask

  task automatic cyc();
    logic  rd_now;
    word_t w;
    @(negedge clk);
    fifo_empty = (fq.size() == 0);
    #1;
    rd_now = fifo_rd;
    check("rd_while_empty", 64'(fifo_rd & fifo_empty), 64'd0);
    if (stall_prev) begin
      check("hold_valid", 64'(m_valid), 64'd1);
      check("hold_data", 64'(m_data), 64'(data_prev));
      check("hold_bytes", 64'(m_bytes), 64'(bytes_prev));
    end
    if (m_valid && m_ready && !rst) begin
      check("word_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("word_data", 64'(m_data), 64'(w.data));
        check("word_bytes", 64'(m_bytes), 64'(w.bytes));
      end
      if (gap_on && last_hs >= 0) check("word_gap", 64'(cyc_n - last_hs), 64'(PACK + 1));
      last_hs = cyc_n;
    end
    stall_prev = m_valid && !m_ready && !rst;
    data_prev  = m_data;
    bytes_prev = m_bytes;
    @(posedge clk);
    #1;
    cyc_n++;
    if (rd_now && fq.size() > 0) begin
      fifo_data = fq.pop_front();
      pops++;
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || busy || fq.size() != 0) && n < max_cyc) begin
      cyc();
      n++;
    end
    check("drain_done", 64'(n < max_cyc), 64'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rd"},    64'(fifo_rd), 64'd0);
    check({tag, "_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_data"},  64'(m_data),  64'd0);
    check({tag, "_bytes"}, 64'(m_bytes), 64'd0);
    check({tag, "_busy"},  64'(busy),    64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; m_ready = 1'b1; fifo_empty = 1'b1; fifo_data = 8'h00;
    repeat (3) cyc();
    rst = 1'b0;
    check_zero_outputs("reset");

    // two full words from 01..08
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_idle(60);

    // streaming throughput: one word every PACK+1 cycles
    gap_on = 1'b1;
    last_hs = -1;
    for (int i = 0; i < 64; i++) push(8'(8'h20 + i));
    wait_idle(400);
    gap_on = 1'b0;

    // output stall: first word held, second assembled, pops stop
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (20) cyc();
    check("stall_valid", 64'(m_valid), 64'd1);
    check("stall_data", 64'(m_data), 64'h04030201);
    check("stall_rd", 64'(fifo_rd), 64'd0);
    check("stall_popped_all", 64'(fq.size()), 64'd0);
    check("stall_busy", 64'(busy), 64'd1);
    m_ready = 1'b1;
    wait_idle(40);

    // partial word flush, then flush with nothing buffered
    push(8'hAA);
    push(8'hBB);
    repeat (4) cyc();
    close_group();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    wait_idle(20);
    check("flush_busy", 64'(busy), 64'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (6) cyc();
    check("empty_flush_busy", 64'(busy), 64'd0);

    // flush while a pop is in flight with fill=2
    pops = 0;
    push(8'h51); push(8'h52); push(8'h53);
    n = 0;
    while (pops < 3 && n < 20) begin
      cyc();
      n++;
    end
    check("third_pop_seen", 64'(pops), 64'd3);
    close_group();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    wait_idle(20);

    // reset mid-word with a stalled output word
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) push(8'(8'h61 + i));
    repeat (15) cyc();
    check("pre_reset_valid", 64'(m_valid), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    grp.delete();
    cyc();
    rst = 1'b0;
    check_zero_outputs("midreset");
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    wait_idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
